// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of any depth with occupancy count, programmable almost flags,
// read-valid strobe, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 6,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  full_s, empty_s, wa_s, ra_s;

  // Wrap is explicit so non-power-of-two depths index only valid entries.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign wa_s    = cs & wr_en & ~full_s;
  assign ra_s    = cs & rd_en & ~empty_s;

  // Next-state logic; flush overrides any access in the same cycle.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (flush) begin
      wp_d       = {PW{1'b0}};
      rp_d       = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      rd_valid_d = 1'b0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end else begin
      if (wa_s) begin
        wp_d = ptr_inc(wp_q);
      end else begin
        wp_d = wp_q;
      end
      if (ra_s) begin
        rp_d   = ptr_inc(rp_q);
        dout_d = mem[rp_q];
      end else begin
        rp_d   = rp_q;
        dout_d = dout_q;
      end
      rd_valid_d = ra_s;
      case ({wa_s, ra_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (cs & wr_en & full_s);
      unf_d = unf_q | (cs & rd_en & empty_s);
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q       <= {PW{1'b0}};
      rp_q       <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      dout_q     <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wa_s && !flush) begin
      mem[wp_q] <= data_in;
    end
  end

  assign data_out     = dout_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags at default parameters (DEPTH=6).
module tb_sync_fifo_flags;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        wr_en;
  logic [31:0] data_in;
  logic        rd_en;
  logic        flush;
  logic [31:0] data_out;
  logic        rd_valid;
  logic        full, empty, almost_full, almost_empty;
  logic [2:0]  count;
  logic        overflow, underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_flags dut (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .flush(flush), .data_out(data_out), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] drain_exp [5];

  initial begin
    rst = 1'b0; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; data_in = 32'h0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Fill 0xA0..0xA5
    cs = 1'b1; wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 32'hA0 + 32'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 5));
      chk("fill_full", 32'(full), 32'((i + 1) == 6));
      chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 1));
    end
    data_in = 32'hFF;
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd6);

    // Drain in order
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("drain_data", data_out, 32'hA0 + 32'(i));
      chk("drain_rdv", 32'(rd_valid), 32'd1);
      chk("drain_count", 32'(count), 32'(5 - i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Two rounds of write-3/read-3, second round crosses index 5->0
    for (int r = 0; r < 2; r++) begin
      rd_en = 1'b0; wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
        data_in = 32'hB0 + 32'(r * 3 + i);
        tick();
      end
      chk("wrap_count", 32'(count), 32'd3);
      wr_en = 1'b0; rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("wrap_data", data_out, 32'hB0 + 32'(r * 3 + i));
      end
    end
    chk("wrap_empty", 32'(empty), 32'd1);
    tick();
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_dout_hold", data_out, 32'hB5);
    chk("unf_rdv", 32'(rd_valid), 32'd0);
    chk("unf_count", 32'(count), 32'd0);

    // Flush clears sticky flags
    rd_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl0_ovf", 32'(overflow), 32'd0);
    chk("fl0_unf", 32'(underflow), 32'd0);

    // Simultaneous read/write at count=3 for 10 cycles
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hC0 + 32'(i);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 32'hC3 + 32'(i);
      tick();
      chk("rw_count", 32'(count), 32'd3);
      chk("rw_data", data_out, 32'hC0 + 32'(i));
      chk("rw_rdv", 32'(rd_valid), 32'd1);
      chk("rw_ovf", 32'(overflow), 32'd0);
      chk("rw_unf", 32'(underflow), 32'd0);
    end

    // Full boundary: contents CA,CB,CC then D0..D2
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hD0 + 32'(i);
      tick();
    end
    chk("fb_full", 32'(full), 32'd1);
    rd_en = 1'b1; data_in = 32'hEE;
    tick();
    chk("fb_count", 32'(count), 32'd5);
    chk("fb_ovf", 32'(overflow), 32'd1);
    chk("fb_data", data_out, 32'hCA);
    chk("fb_rdv", 32'(rd_valid), 32'd1);
    wr_en = 1'b0;
    drain_exp[0] = 32'hCB; drain_exp[1] = 32'hCC; drain_exp[2] = 32'hD0;
    drain_exp[3] = 32'hD1; drain_exp[4] = 32'hD2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fb_drain", data_out, drain_exp[i]);
    end
    chk("fb_empty", 32'(empty), 32'd1);

    // Empty boundary
    wr_en = 1'b1; data_in = 32'h77;
    tick();
    chk("eb_count", 32'(count), 32'd1);
    chk("eb_unf", 32'(underflow), 32'd1);
    chk("eb_rdv", 32'(rd_valid), 32'd0);
    chk("eb_dout", data_out, 32'hD2);
    wr_en = 1'b0;
    tick();
    chk("eb_read", data_out, 32'h77);

    // Flush at count=4 with both requests high
    rd_en = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'hE0 + 32'(i);
      tick();
    end
    chk("fl_pre_count", 32'(count), 32'd4);
    rd_en = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_ovf", 32'(overflow), 32'd0);
    chk("fl_unf", 32'(underflow), 32'd0);
    chk("fl_rdv", 32'(rd_valid), 32'd0);
    chk("fl_dout_hold", data_out, 32'h77);

    // Async reset mid-burst
    wr_en = 1'b1;
    data_in = 32'hF0; tick();
    data_in = 32'hF1; tick();
    chk("ar_pre_count", 32'(count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_dout", data_out, 32'd0);
    #1;
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    chk("ar_first_unf", 32'(underflow), 32'd1);
    chk("ar_first_rdv", 32'(rd_valid), 32'd0);
    rd_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;

    // cs low: nothing changes, no errors
    wr_en = 1'b1; data_in = 32'h55;
    tick();
    tick();
    chk("cs_pre_count", 32'(count), 32'd2);
    cs = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cs_count", 32'(count), 32'd2);
      chk("cs_rdv", 32'(rd_valid), 32'd0);
      chk("cs_dout", data_out, 32'd0);
    end
    flush = 1'b1; cs = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    flush = 1'b0; cs = 1'b0; rd_en = 1'b1;
    tick();
    chk("cs_empty_unf", 32'(underflow), 32'd0);
    cs = 1'b0; rd_en = 1'b0; wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
